// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU: opcode constants, fetch state encoding
// and default datapath widths used by the fetch stage and control.
package cpu_pkg;

  localparam int DEF_ADDR_W  = 16;
  localparam int DEF_INSTR_W = 16;

  localparam logic [3:0] OP_HALT  = 4'b0000;
  localparam logic [3:0] OP_LOAD  = 4'b1000;
  localparam logic [3:0] OP_STORE = 4'b1001;
  localparam logic [3:0] OP_BEQ   = 4'b1010;
  localparam logic [3:0] OP_BNE   = 4'b1011;
  localparam logic [3:0] OP_JMP   = 4'b1100;
  localparam logic [3:0] OP_TYPEA = 4'b1111;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    FULL   = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } fetch_state_e;

  function automatic logic is_halt(input logic [3:0] op);
    return (op == OP_HALT);
  endfunction

  function automatic logic is_flow_change(input logic [3:0] op);
    return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_JMP);
  endfunction

endpackage

// File: rtl/fetch_skid.sv
// Single-entry holding register for an instruction word and its address, used
// when a memory response arrives while IF/ID is stalled.
module fetch_skid
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int INSTR_W = DEF_INSTR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               pop,
  input  logic               clear,
  input  logic [INSTR_W-1:0] load_instr,
  input  logic [ADDR_W-1:0]  load_pc,
  output logic               valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  pc
);

  logic               valid_r;
  logic [INSTR_W-1:0] instr_r;
  logic [ADDR_W-1:0]  pc_r;

  // Holding register; clear outranks load so a flush never keeps stale data.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= 1'b0;
      instr_r <= {INSTR_W{1'b0}};
      pc_r    <= {ADDR_W{1'b0}};
    end else if (clear) begin
      valid_r <= 1'b0;
    end else if (load) begin
      valid_r <= 1'b1;
      instr_r <= load_instr;
      pc_r    <= load_pc;
    end else if (pop) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

  assign valid = valid_r;
  assign instr = instr_r;
  assign pc    = pc_r;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID register, single-outstanding memory requests,
// redirect/stall/halt handling. Optional counters: define FETCH_PERF_CNT_EN.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                INSTR_W  = DEF_INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imemReq,
  output logic [ADDR_W-1:0]  imemAddr,
  input  logic               imemValid,
  input  logic [INSTR_W-1:0] imemData,
  input  logic               stall,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirectPc,
  output logic               ifIdValid,
  output logic [INSTR_W-1:0] ifIdInstr,
  output logic [ADDR_W-1:0]  ifIdPc,
  output logic [3:0]         opcode,
  output logic [1:0]         multiDiv,
  output logic               halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        fetchCount,
  output logic [31:0]        flushCount
`endif
);

  fetch_state_e       state_r, state_nxt_s;
  logic [ADDR_W-1:0]  pc_r, pc_nxt_s;
  logic [ADDR_W-1:0]  drain_pc_r, drain_pc_nxt_s;
  logic               if_valid_r, if_valid_nxt_s;
  logic [INSTR_W-1:0] if_instr_r, if_instr_nxt_s;
  logic [ADDR_W-1:0]  if_pc_r, if_pc_nxt_s;

  logic               can_load_s;
  logic               word_loaded_s;
  logic [ADDR_W-1:0]  pc_inc_s;
  logic [ADDR_W-1:0]  redirect_pc_s;

  logic               skid_load_s, skid_pop_s, skid_clear_s;
  logic               skid_valid_s;
  logic [INSTR_W-1:0] skid_instr_s;
  logic [ADDR_W-1:0]  skid_pc_s;

  assign can_load_s    = !if_valid_r || !stall;
  assign pc_inc_s      = pc_r + ADDR_W'(2);
  assign redirect_pc_s = redirectPc & ~ADDR_W'(1);

  fetch_skid #(
    .ADDR_W (ADDR_W),
    .INSTR_W(INSTR_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .load      (skid_load_s),
    .pop       (skid_pop_s),
    .clear     (skid_clear_s),
    .load_instr(imemData),
    .load_pc   (pc_r),
    .valid     (skid_valid_s),
    .instr     (skid_instr_s),
    .pc        (skid_pc_s)
  );

  // Next-state, PC and IF/ID update; redirect overrides stall and halt.
  always_comb begin
    state_nxt_s    = state_r;
    pc_nxt_s       = pc_r;
    drain_pc_nxt_s = drain_pc_r;
    if_valid_nxt_s = if_valid_r;
    if_instr_nxt_s = if_instr_r;
    if_pc_nxt_s    = if_pc_r;
    skid_load_s    = 1'b0;
    skid_pop_s     = 1'b0;
    skid_clear_s   = 1'b0;
    word_loaded_s  = 1'b0;

    if (redirect) begin
      pc_nxt_s       = redirect_pc_s;
      if_valid_nxt_s = 1'b0;
      skid_clear_s   = 1'b1;
      case (state_r)
        FETCH: begin
          if (imemValid) begin
            state_nxt_s = FETCH;
          end else begin
            // The old request is still in flight; keep presenting its address.
            state_nxt_s    = DRAIN;
            drain_pc_nxt_s = pc_r;
          end
        end
        DRAIN: begin
          if (imemValid) begin
            state_nxt_s = FETCH;
          end else begin
            state_nxt_s = DRAIN;
          end
        end
        FULL:    state_nxt_s = FETCH;
        HALTED:  state_nxt_s = FETCH;
        default: state_nxt_s = FETCH;
      endcase
    end else begin
      case (state_r)
        FETCH: begin
          if (imemValid) begin
            pc_nxt_s = pc_inc_s;
            if (can_load_s) begin
              if_valid_nxt_s = 1'b1;
              if_instr_nxt_s = imemData;
              if_pc_nxt_s    = pc_r;
              word_loaded_s  = 1'b1;
              if (is_halt(imemData[INSTR_W-1 -: 4])) begin
                state_nxt_s = HALTED;
              end else begin
                state_nxt_s = FETCH;
              end
            end else begin
              skid_load_s = 1'b1;
              state_nxt_s = FULL;
            end
          end else if (!stall) begin
            // Decode consumed the current word and nothing replaces it.
            if_valid_nxt_s = 1'b0;
          end else begin
            if_valid_nxt_s = if_valid_r;
          end
        end
        FULL: begin
          if (!stall && skid_valid_s) begin
            if_valid_nxt_s = 1'b1;
            if_instr_nxt_s = skid_instr_s;
            if_pc_nxt_s    = skid_pc_s;
            skid_pop_s     = 1'b1;
            word_loaded_s  = 1'b1;
            if (is_halt(skid_instr_s[INSTR_W-1 -: 4])) begin
              state_nxt_s = HALTED;
            end else begin
              state_nxt_s = FETCH;
            end
          end else begin
            state_nxt_s = FULL;
          end
        end
        DRAIN: begin
          if (imemValid) begin
            state_nxt_s = FETCH;
          end else begin
            state_nxt_s = DRAIN;
          end
        end
        HALTED: begin
          state_nxt_s = HALTED;
        end
        default: begin
          state_nxt_s = FETCH;
        end
      endcase
    end
  end

  // State, PC and IF/ID registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= FETCH;
      pc_r       <= RESET_PC;
      drain_pc_r <= {ADDR_W{1'b0}};
      if_valid_r <= 1'b0;
      if_instr_r <= {INSTR_W{1'b0}};
      if_pc_r    <= {ADDR_W{1'b0}};
    end else begin
      state_r    <= state_nxt_s;
      pc_r       <= pc_nxt_s;
      drain_pc_r <= drain_pc_nxt_s;
      if_valid_r <= if_valid_nxt_s;
      if_instr_r <= if_instr_nxt_s;
      if_pc_r    <= if_pc_nxt_s;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Loaded-instruction and redirect-cycle counters, free-running with wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetchCount <= 32'd0;
      flushCount <= 32'd0;
    end else begin
      fetchCount <= fetchCount + (word_loaded_s ? 32'd1 : 32'd0);
      flushCount <= flushCount + (redirect ? 32'd1 : 32'd0);
    end
  end
`endif

  assign imemReq   = (state_r == FETCH) || (state_r == DRAIN);
  assign imemAddr  = (state_r == DRAIN) ? drain_pc_r : pc_r;
  assign halted    = (state_r == HALTED);
  assign ifIdValid = if_valid_r;
  assign ifIdInstr = if_instr_r;
  assign ifIdPc    = if_pc_r;
  assign opcode    = if_instr_r[INSTR_W-1 -: 4];
  assign multiDiv  = if_instr_r[1:0];

endmodule
